// File: rtl/adc_display_scheduler.sv
// Rate-limited ADC-to-HEX display controller: captures the latest sample, converts it with a
// bit-serial double-dabble engine on each refresh tick and drives five active-low 7-seg digits.
module adc_display_scheduler #(
  parameter int unsigned UPDATE_DIV = 5_000_000,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] in_data,
  input  logic        in_valid,
  input  logic        freeze,
  output logic        busy,
  output logic        upd_done,
  output logic [6:0]  d0,
  output logic [6:0]  d1,
  output logic [6:0]  d2,
  output logic [6:0]  d3,
  output logic [6:0]  d4
);

  localparam int unsigned     CntW   = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(UPDATE_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic [13:0]     sample_q;
  logic            have_sample_q;
  logic [13:0]     bin_q, bin_d;
  logic [19:0]     bcd_q, bcd_d, bcd_adj;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            load;
  logic            latch_q;
  logic            lz_run;
  logic [6:0]      seg_enc [5];

  function automatic logic [6:0] seg7(input logic [3:0] dig);
    case (dig)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick = (cnt_q == CntMax);

  // Free-running refresh divider; keeps counting through conversions and freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CntW'(1);
  end

  // Latest-sample capture; a new sample in the load cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q      <= '0;
      have_sample_q <= 1'b0;
    end else if (in_valid) begin
      sample_q      <= in_data;
      have_sample_q <= 1'b1;
    end else if (load) begin
      have_sample_q <= 1'b0;
    end
  end

  // Double-dabble add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // FSM next state and conversion datapath.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ticks without a fresh sample or under freeze are dropped, not queued.
        if (tick && have_sample_q && !freeze) begin
          load      = 1'b1;
          bin_d     = sample_q;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = StConv;
        end
      end
      StConv: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        bit_cnt_d      = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd13) state_d = StLatch;
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath registers; busy and the latch strobe trail the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      latch_q   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      latch_q   <= (state_q == StLatch);
      busy      <= (state_q != StIdle);
    end
  end

  // Segment encoding with optional leading-zero blanking; units digit is never blanked.
  always_comb begin
    lz_run = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      lz_run     = lz_run & (bcd_q[4*i +: 4] == 4'd0);
      seg_enc[i] = (BLANK_LZ && lz_run) ? 7'h7F : seg7(bcd_q[4*i +: 4]);
    end
    seg_enc[0] = seg7(bcd_q[3:0]);
  end

  // Registered display outputs and the one-cycle update pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_done <= 1'b0;
      d0       <= 7'h40;
      d1       <= 7'h40;
      d2       <= 7'h40;
      d3       <= 7'h40;
      d4       <= 7'h40;
    end else begin
      upd_done <= latch_q;
      if (latch_q) begin
        d0 <= seg_enc[0];
        d1 <= seg_enc[1];
        d2 <= seg_enc[2];
        d3 <= seg_enc[3];
        d4 <= seg_enc[4];
      end
    end
  end

endmodule

// File: tb/tb_adc_display_scheduler.sv
// Scoreboard bench: a reference model predicts each conversion at its tick and queues the
// value with its due cycle; a negedge checker compares both DUT variants every cycle.
module tb_adc_display_scheduler;

  localparam int Div = 32;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [13:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        freeze   = 1'b0;

  logic       busy_a, upd_a, busy_b, upd_b;
  logic [6:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  int   m_sample = 0;
  bit   m_have = 1'b0;
  exp_t q[$];
  int   disp_val = 0;
  bit   disp_rst = 1'b1;
  bit   e_upd, e_busy;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  adc_display_scheduler #(.UPDATE_DIV(Div), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .freeze(freeze),
    .busy(busy_a), .upd_done(upd_a), .d0(a0), .d1(a1), .d2(a2), .d3(a3), .d4(a4)
  );

  adc_display_scheduler #(.UPDATE_DIV(Div), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .freeze(freeze),
    .busy(busy_b), .upd_done(upd_b), .d0(b0), .d1(b1), .d2(b2), .d3(b3), .d4(b4)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [34:0] exp_segs(input int v, input bit lz, input bit rz);
    logic [34:0] r;
    int          p;
    int          dig;
    bit          lead;
    r    = '0;
    p    = 10000;
    lead = 1'b1;
    if (rz) return {5{7'h40}};
    for (int i = 4; i >= 0; i--) begin
      dig             = (v / p) % 10;
      lead            = lead && (dig == 0) && (i != 0);
      r[7*i +: 7]     = (lz && lead) ? 7'h7F : seg_tab[dig];
      p               = p / 10;
    end
    return r;
  endfunction

  // Reference model: the conversion launched at tick edge E lands on the display at E+16.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt    = 0;
      m_have   = 1'b0;
      m_sample = 0;
      q.delete();
    end else begin
      if (m_cnt == Div - 1 && m_have && !freeze) begin
        q.push_back(exp_t'{m_sample, cyc + 17});
        m_have = 1'b0;
      end
      if (in_valid) begin
        m_sample = int'(in_data);
        m_have   = 1'b1;
      end
      m_cnt = (m_cnt == Div - 1) ? 0 : m_cnt + 1;
    end
  end

  // Per-cycle scoreboard check on the falling edge.
  initial forever begin
    @(negedge clk);
    e_upd = 1'b0;
    if (rst) begin
      disp_rst = 1'b1;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e_upd    = 1'b1;
      disp_val = q[0].val;
      disp_rst = 1'b0;
      void'(q.pop_front());
    end
    e_busy = 1'b0;
    foreach (q[i]) if (cyc >= q[i].due - 15 && cyc <= q[i].due - 1) e_busy = 1'b1;
    check_eq("upd_done", upd_a, e_upd);
    check_eq("upd_done_lz", upd_b, e_upd);
    check_eq("busy", busy_a, e_busy);
    check_eq("busy_lz", busy_b, e_busy);
    check_eq("segs", {a4, a3, a2, a1, a0}, exp_segs(disp_val, 1'b0, disp_rst));
    check_eq("segs_lz", {b4, b3, b2, b1, b0}, exp_segs(disp_val, 1'b1, disp_rst));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v);
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = 14'(v);
    @(negedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic set_freeze(input bit v);
    #2;
    freeze = v;
  endtask

  // Stop on the falling edge where the model's divider reads val.
  task automatic wait_cnt(input int val);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * Div && !found; i++) begin
      @(negedge clk);
      if (m_cnt == val) found = 1'b1;
    end
    check_eq("wait_cnt", found, 1'b1);
  endtask

  // Stop k cycles after the tick that launched the oldest pending conversion.
  task automatic wait_conv(input int k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (q.size() > 0 && cyc == q[0].due - 16 + k) found = 1'b1;
    end
    check_eq("wait_conv", found, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    // Quiet after reset: zeros shown, no activity.
    idle(200);
    // Plain conversions, including full scale and zero.
    send(12345); idle(80);
    send(16383); idle(80);
    send(0);     idle(80);
    send(7);     idle(80);
    // Freeze blocks a pending sample until released.
    set_freeze(1'b1); send(9999); idle(80);
    set_freeze(1'b0); idle(80);
    // Freeze rising mid-conversion lets that result through, then blocks.
    send(500); wait_conv(4); set_freeze(1'b1); idle(40);
    send(600); idle(80);
    set_freeze(1'b0); idle(80);
    // Reset in the middle of a conversion.
    send(4321); wait_conv(8);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_segs", {a4, a3, a2, a1, a0}, {5{7'h40}});
    check_eq("rst_segs_lz", {b4, b3, b2, b1, b0}, {5{7'h40}});
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_upd", upd_a, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(4321); idle(80);
    // New sample in the load cycle: old one converts, new one follows on the next tick.
    wait_cnt(5); send(50);
    wait_cnt(Div - 1);
    #2;
    in_valid = 1'b1;
    in_data  = 14'd111;
    @(negedge clk);
    #2 in_valid = 1'b0;
    idle(40);
    send(222); idle(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
